demux_1_n_stream: RTL and testbench

- Parametrised 1:N registered stream demultiplexer with valid/ready handshake on the input and on every output channel.
- Each input beat is steered by its select field into a per-channel one-entry holding register.
- Out-of-range selects are consumed and flagged.
- Sits between a single producer and N independent consumers; supersedes the fixed combinational 1:2 demux.

---
 rtl/demux_1_n_stream.sv | 134 +++++++++++++
 tb/tb_demux_1_n_stream.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_n_stream.sv
// ---------------------------------------------------------------------------
// demux_1_n_stream
//
// Registered 1:N stream demultiplexer. Each input beat is steered by in_sel
// into a one-entry holding register for that channel. A beat whose select is
// outside 0..N_CH-1 is always accepted, discarded, and reported on
// drop_pulse one cycle later.
//
// Handshake rule (input and every output channel): a beat moves on a rising
// clk edge where valid && ready are both high. valid never waits on ready;
// once raised, valid and data hold steady until the transfer happens.
// in_ready is combinational from in_sel, out_valid and out_ready only, and
// never looks at in_valid.
//
// Parameters:
//   N_CH   : number of output channels (2..16)
//   DATA_W : payload width
//   SEL_W  : select width, N_CH <= 2**SEL_W
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : input payload
//   in_sel     : destination channel index
//   in_valid   : producer has a beat
//   in_ready   : block accepts the beat this cycle
//   out_data   : flattened, channel c at [c*DATA_W +: DATA_W]
//   out_valid  : channel c holds a beat
//   out_ready  : consumer c accepts this cycle
//   drop_pulse : one-cycle pulse after an out-of-range beat was consumed
//
// Optional feature, macro DEMUX_XFER_CNT_EN:
//   cnt_clr    : synchronous clear of all transfer counters
//   xfer_cnt   : flattened 16-bit saturating per-channel handshake counters,
//                channel c at [c*16 +: 16]
// ---------------------------------------------------------------------------
module demux_1_n_stream #(
   parameter int N_CH   = 4,
   parameter int DATA_W = 8,
   parameter int SEL_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_W-1:0]      in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [N_CH*DATA_W-1:0] out_data,
   output logic [N_CH-1:0]        out_valid,
   input  logic [N_CH-1:0]        out_ready,
`ifdef DEMUX_XFER_CNT_EN
   input  logic                   cnt_clr,
   output logic [N_CH*16-1:0]     xfer_cnt,
`endif
   output logic                   drop_pulse
);

   int                sel_int;
   logic              in_range;
   logic [N_CH-1:0]   load;
   logic              drop_q;
   logic [DATA_W-1:0] data_q [N_CH];
   logic [N_CH-1:0]   valid_q;

   assign sel_int  = int'(in_sel);
   assign in_range = (sel_int < N_CH);

   // Out-of-range beats are always taken; an in-range beat may enter if its
   // slot is empty or is being drained in this same cycle.
   always_comb begin
      in_ready = 1'b1;
      for (int c = 0; c < N_CH; c++) begin
         if (sel_int == c) begin
            in_ready = !valid_q[c] || out_ready[c];
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_CH; g++) begin : g_ch
         assign load[g] = in_valid && in_ready && (sel_int == g);

         // A load in the same cycle as a drain wins, keeping the slot full
         // so a channel sustains one beat per cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_q[g] <= 1'b0;
               data_q[g]  <= '0;
            end else if (load[g]) begin
               valid_q[g] <= 1'b1;
               data_q[g]  <= in_data;
            end else if (out_ready[g]) begin
               valid_q[g] <= 1'b0;
            end
         end

         assign out_data[g*DATA_W +: DATA_W] = data_q[g];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= in_valid && !in_range;
      end
   end

   assign out_valid  = valid_q;
   assign drop_pulse = drop_q;

`ifdef DEMUX_XFER_CNT_EN
   logic [15:0] cnt_q [N_CH];

   generate
      for (g = 0; g < N_CH; g++) begin : g_cnt
         // Clear has priority; the count sticks at all-ones.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q[g] <= '0;
            end else if (cnt_clr) begin
               cnt_q[g] <= '0;
            end else if (valid_q[g] && out_ready[g] && (cnt_q[g] != 16'hFFFF)) begin
               cnt_q[g] <= cnt_q[g] + 16'd1;
            end
         end

         assign xfer_cnt[g*16 +: 16] = cnt_q[g];
      end
   endgenerate
`endif

endmodule

// File: tb/tb_demux_1_n_stream.sv
// ---------------------------------------------------------------------------
// tb_demux_1_n_stream
//
// Directed bench for demux_1_n_stream. Instance dut_a uses the defaults
// (N_CH=4, DATA_W=8, SEL_W=2); instance dut_b uses N_CH=3, SEL_W=2 so that
// select value 3 is out of range. Inputs change just after the falling
// edge; outputs are sampled at the falling edge or #1 after an input change,
// always away from the rising edge.
// ---------------------------------------------------------------------------
module tb_demux_1_n_stream;

   logic        clk;
   logic        rst_n;

   // dut_a signals
   logic [7:0]  a_in_data;
   logic [1:0]  a_in_sel;
   logic        a_in_valid;
   logic        a_in_ready;
   logic [31:0] a_out_data;
   logic [3:0]  a_out_valid;
   logic [3:0]  a_out_ready;
   logic        a_drop_pulse;

   // dut_b signals
   logic [7:0]  b_in_data;
   logic [1:0]  b_in_sel;
   logic        b_in_valid;
   logic        b_in_ready;
   logic [23:0] b_out_data;
   logic [2:0]  b_out_valid;
   logic [2:0]  b_out_ready;
   logic        b_drop_pulse;

`ifdef DEMUX_XFER_CNT_EN
   logic        a_cnt_clr;
   logic [63:0] a_xfer_cnt;
   logic        b_cnt_clr;
   logic [47:0] b_xfer_cnt;
`endif

   int tests_run;
   int tests_failed;
   logic [7:0] exp_q[$];

   demux_1_n_stream #(.N_CH(4), .DATA_W(8), .SEL_W(2)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (a_in_data),
      .in_sel     (a_in_sel),
      .in_valid   (a_in_valid),
      .in_ready   (a_in_ready),
      .out_data   (a_out_data),
      .out_valid  (a_out_valid),
      .out_ready  (a_out_ready),
`ifdef DEMUX_XFER_CNT_EN
      .cnt_clr    (a_cnt_clr),
      .xfer_cnt   (a_xfer_cnt),
`endif
      .drop_pulse (a_drop_pulse)
   );

   demux_1_n_stream #(.N_CH(3), .DATA_W(8), .SEL_W(2)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (b_in_data),
      .in_sel     (b_in_sel),
      .in_valid   (b_in_valid),
      .in_ready   (b_in_ready),
      .out_data   (b_out_data),
      .out_valid  (b_out_valid),
      .out_ready  (b_out_ready),
`ifdef DEMUX_XFER_CNT_EN
      .cnt_clr    (b_cnt_clr),
      .xfer_cnt   (b_xfer_cnt),
`endif
      .drop_pulse (b_drop_pulse)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic drive_a(input logic [7:0] d, input logic [1:0] s, input logic v);
      a_in_data  = d;
      a_in_sel   = s;
      a_in_valid = v;
   endtask

   task automatic drive_b(input logic [7:0] d, input logic [1:0] s, input logic v);
      b_in_data  = d;
      b_in_sel   = s;
      b_in_valid = v;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      drive_a(8'h00, 2'd0, 1'b0);
      drive_b(8'h00, 2'd0, 1'b0);
      a_out_ready = 4'h0;
      b_out_ready = 3'h0;
`ifdef DEMUX_XFER_CNT_EN
      a_cnt_clr = 1'b0;
      b_cnt_clr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      tests_run++;
      if (a_out_valid !== 4'h0 || a_out_data !== 32'h0 || a_drop_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_hold: valid=%h data=%h drop=%b, expected 0/0/0", a_out_valid, a_out_data, a_drop_pulse);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (a_out_valid !== 4'h0 || a_out_data !== 32'h0 || a_drop_pulse !== 1'b0 ||
          b_out_valid !== 3'h0 || b_out_data !== 24'h0 || b_drop_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: a_valid=%h a_data=%h b_valid=%h b_data=%h, expected all 0", a_out_valid, a_out_data, b_out_valid, b_out_data);
      end
      for (int s = 0; s < 4; s++) begin
         a_in_sel = 2'(s);
         b_in_sel = 2'(s);
         #1;
         tests_run++;
         if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready sel=%0d: a=%b b=%b, expected 1", s, a_in_ready, b_in_ready);
         end
      end
   endtask

   task automatic test_basic_steer;
      @(negedge clk);
      a_out_ready = 4'hF;
      drive_a(8'hA5, 2'd0, 1'b1);
      @(negedge clk);
      tests_run++;
      if (a_out_valid !== 4'b0001 || a_out_data[7:0] !== 8'hA5) begin
         tests_failed++;
         $display("FAIL steer_ch0: valid=%b data0=%h, expected 0001/a5", a_out_valid, a_out_data[7:0]);
      end
      drive_a(8'h3C, 2'd3, 1'b1);
      @(negedge clk);
      drive_a(8'h00, 2'd0, 1'b0);
      tests_run++;
      if (a_out_valid !== 4'b1000 || a_out_data[31:24] !== 8'h3C || a_out_data[23:8] !== 16'h0) begin
         tests_failed++;
         $display("FAIL steer_ch3: valid=%b data=%h, expected 1000/3c0000a5", a_out_valid, a_out_data);
      end
      @(negedge clk);
      tests_run++;
      if (a_out_valid !== 4'b0000 || a_out_data !== 32'h3C0000A5) begin
         tests_failed++;
         $display("FAIL steer_drain: valid=%b data=%h, expected 0000/3c0000a5", a_out_valid, a_out_data);
      end
   endtask

   task automatic test_backpressure;
      a_out_ready = 4'b1101;
      drive_a(8'h11, 2'd1, 1'b1);
      @(negedge clk);
      drive_a(8'h22, 2'd1, 1'b1);
      #1;
      tests_run++;
      if (a_in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_in_ready_low: got %b, expected 0", a_in_ready);
      end
      a_in_sel = 2'd2;
      #1;
      tests_run++;
      if (a_in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_other_ch_ready: got %b, expected 1", a_in_ready);
      end
      a_in_sel = 2'd1;
      @(negedge clk);
      tests_run++;
      if (a_out_valid[1] !== 1'b1 || a_out_data[15:8] !== 8'h11) begin
         tests_failed++;
         $display("FAIL bp_hold: valid1=%b data1=%h, expected 1/11", a_out_valid[1], a_out_data[15:8]);
      end
      a_out_ready = 4'hF;
      #1;
      tests_run++;
      if (a_in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_in_ready_high: got %b, expected 1", a_in_ready);
      end
      @(negedge clk);
      drive_a(8'h00, 2'd0, 1'b0);
      tests_run++;
      if (a_out_valid[1] !== 1'b1 || a_out_data[15:8] !== 8'h22) begin
         tests_failed++;
         $display("FAIL bp_drain_load: valid1=%b data1=%h, expected 1/22", a_out_valid[1], a_out_data[15:8]);
      end
      @(negedge clk);
      tests_run++;
      if (a_out_valid[1] !== 1'b0 || a_out_data[15:8] !== 8'h22) begin
         tests_failed++;
         $display("FAIL bp_retain: valid1=%b data1=%h, expected 0/22", a_out_valid[1], a_out_data[15:8]);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp;
      a_out_ready = 4'hF;
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            exp = exp_q.pop_front();
            tests_run++;
            if (a_out_valid[2] !== 1'b1 || a_out_data[23:16] !== exp) begin
               tests_failed++;
               $display("FAIL b2b_data beat=%0d: valid2=%b data2=%h, expected 1/%h", i - 1, a_out_valid[2], a_out_data[23:16], exp);
            end
         end
         if (i < 8) begin
            drive_a(8'(i), 2'd2, 1'b1);
            exp_q.push_back(8'(i));
            #1;
            tests_run++;
            if (a_in_ready !== 1'b1) begin
               tests_failed++;
               $display("FAIL b2b_in_ready beat=%0d: got %b, expected 1", i, a_in_ready);
            end
         end else begin
            drive_a(8'h00, 2'd0, 1'b0);
         end
         @(negedge clk);
      end
      tests_run++;
      if (a_out_valid !== 4'h0) begin
         tests_failed++;
         $display("FAIL b2b_empty: valid=%b, expected 0000", a_out_valid);
      end
   endtask

   task automatic test_out_of_range;
      b_out_ready = 3'b000;
      drive_b(8'h5A, 2'd1, 1'b1);
      @(negedge clk);
      tests_run++;
      if (b_out_valid !== 3'b010 || b_drop_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL oor_preload: valid=%b drop=%b, expected 010/0", b_out_valid, b_drop_pulse);
      end
      drive_b(8'h77, 2'd3, 1'b1);
      #1;
      tests_run++;
      if (b_in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL oor_in_ready: got %b, expected 1", b_in_ready);
      end
      @(negedge clk);
      drive_b(8'h00, 2'd0, 1'b0);
      tests_run++;
      if (b_drop_pulse !== 1'b1 || b_out_valid !== 3'b010 || b_out_data !== 24'h005A00) begin
         tests_failed++;
         $display("FAIL oor_drop: drop=%b valid=%b data=%h, expected 1/010/005a00", b_drop_pulse, b_out_valid, b_out_data);
      end
      @(negedge clk);
      tests_run++;
      if (b_drop_pulse !== 1'b0 || b_out_valid !== 3'b010) begin
         tests_failed++;
         $display("FAIL oor_pulse_end: drop=%b valid=%b, expected 0/010", b_drop_pulse, b_out_valid);
      end
   endtask

   task automatic test_reset_mid_transfer;
      a_out_ready = 4'h0;
      drive_a(8'h99, 2'd0, 1'b1);
      @(negedge clk);
      drive_a(8'h00, 2'd0, 1'b0);
      tests_run++;
      if (a_out_valid !== 4'b0001 || a_out_data[7:0] !== 8'h99) begin
         tests_failed++;
         $display("FAIL mid_load: valid=%b data0=%h, expected 0001/99", a_out_valid, a_out_data[7:0]);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (a_out_valid !== 4'h0 || a_out_data !== 32'h0 || b_out_valid !== 3'h0 || b_out_data !== 24'h0) begin
         tests_failed++;
         $display("FAIL mid_async_reset: a_valid=%b a_data=%h b_valid=%b b_data=%h, expected all 0", a_out_valid, a_out_data, b_out_valid, b_out_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (a_out_valid !== 4'h0 || a_drop_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_after_release: valid=%b drop=%b, expected 0/0", a_out_valid, a_drop_pulse);
      end
   endtask

`ifdef DEMUX_XFER_CNT_EN
   // Presents k beats to channel 0 with all consumers ready, then one idle
   // cycle so the last held beat is also handed over: k handshakes total.
   task automatic burst_ch0(input int k);
      a_out_ready = 4'hF;
      drive_a(8'h5C, 2'd0, 1'b1);
      repeat (k) @(negedge clk);
      drive_a(8'h00, 2'd0, 1'b0);
      @(negedge clk);
   endtask

   task automatic test_xfer_cnt;
      burst_ch0(5);
      tests_run++;
      if (a_xfer_cnt[15:0] !== 16'd5 || a_xfer_cnt[63:16] !== 48'h0) begin
         tests_failed++;
         $display("FAIL cnt_five: got %h, expected 0000_0000_0000_0005", a_xfer_cnt);
      end
      a_cnt_clr = 1'b1;
      @(negedge clk);
      a_cnt_clr = 1'b0;
      tests_run++;
      if (a_xfer_cnt !== 64'h0) begin
         tests_failed++;
         $display("FAIL cnt_clear: got %h, expected 0", a_xfer_cnt);
      end
      // 65538 handshakes: a wrapping counter would show 2 here.
      burst_ch0(65538);
      tests_run++;
      if (a_xfer_cnt[15:0] !== 16'hFFFF) begin
         tests_failed++;
         $display("FAIL cnt_saturate: got %h, expected ffff", a_xfer_cnt[15:0]);
      end
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_basic_steer();
      test_backpressure();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_transfer();
`ifdef DEMUX_XFER_CNT_EN
      test_xfer_cnt();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
